// File: rtl/risc_mini_pkg.sv
// Shared definitions for the mini RISC writeback path.
//   REG_AW    : register address width for the default 32-entry file
//   wb_src_t  : identifies which producer owns the write port this cycle
//   wb_req_t  : one writeback request {addr, data} at default widths
package risc_mini_pkg;
  localparam int DEPTH_DEF = 32;
  localparam int WIDTH_DEF = 32;
  localparam int REG_AW    = $clog2(DEPTH_DEF);

  typedef enum logic {WB_SRC_ALU, WB_SRC_LSU} wb_src_t;

  typedef struct packed {
    logic [REG_AW-1:0]    addr;
    logic [WIDTH_DEF-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_hold_slot.sv
// One-entry valid/ready holding register for a writeback source.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   in_valid    : producer offers in_data
//   in_ready    : slot can take in_data this edge (empty, or draining now)
//   in_data     : packed {addr, data}
//   grant       : arbiter is consuming the held entry this cycle
//   v, data     : held entry
module wb_hold_slot #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         grant,
  output logic         v,
  output logic [W-1:0] data
);
  // A granted slot empties this edge, so it may refill at the same edge.
  assign in_ready = !v || grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v    <= 1'b0;
      data <= '0;
    end else if (in_valid && in_ready) begin
      v    <= 1'b1;
      data <= in_data;
    end else if (grant) begin
      v    <= 1'b0;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and LSU writeback results onto the register file's single
// synchronous write port. LSU wins contention unless the ALU has lost
// STARVE_MAX times in a row. Writes to x0 are consumed silently.
// Optional macro WB_BYPASS_EN: forwards the in-flight write (wb_*) onto the
// two read ports and drops that term from query_hit.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   alu_valid/ready/addr/data        : ALU result handshake
//   lsu_valid/ready/addr/data        : LSU result handshake
//   wb_we, wb_waddr, wb_wdata        : registered register-file write port
//   query_addr, query_hit            : pending-write hazard query (comb.)
//   idle                             : nothing held and no write in flight
//   byp_raddr1/2, byp_rs1/2_in       : register-file read address / raw data
//   byp_rs1/2                        : read data after optional bypass
module regfile_wb_arbiter
  import risc_mini_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int WIDTH      = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [$clog2(DEPTH)-1:0] alu_addr,
  input  logic [WIDTH-1:0]         alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [$clog2(DEPTH)-1:0] lsu_addr,
  input  logic [WIDTH-1:0]         lsu_data,
  output logic                     wb_we,
  output logic [$clog2(DEPTH)-1:0] wb_waddr,
  output logic [WIDTH-1:0]         wb_wdata,
  input  logic [$clog2(DEPTH)-1:0] query_addr,
  output logic                     query_hit,
  output logic                     idle,
  input  logic [$clog2(DEPTH)-1:0] byp_raddr1,
  input  logic [$clog2(DEPTH)-1:0] byp_raddr2,
  input  logic [WIDTH-1:0]         byp_rs1_in,
  input  logic [WIDTH-1:0]         byp_rs2_in,
  output logic [WIDTH-1:0]         byp_rs1,
  output logic [WIDTH-1:0]         byp_rs2
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic              v_alu, v_lsu;
  logic [AW+WIDTH-1:0] alu_slot, lsu_slot, win;
  logic [AW-1:0]     alu_slot_addr, lsu_slot_addr, win_addr;
  logic              grant_alu, grant_lsu, any_grant;
  wb_src_t           win_src;
  logic [SW-1:0]     starve_cnt;

  wb_hold_slot #(.W(AW+WIDTH)) u_alu_slot (
    .clk(clk), .rst_n(rst_n),
    .in_valid(alu_valid), .in_ready(alu_ready), .in_data({alu_addr, alu_data}),
    .grant(grant_alu), .v(v_alu), .data(alu_slot)
  );

  wb_hold_slot #(.W(AW+WIDTH)) u_lsu_slot (
    .clk(clk), .rst_n(rst_n),
    .in_valid(lsu_valid), .in_ready(lsu_ready), .in_data({lsu_addr, lsu_data}),
    .grant(grant_lsu), .v(v_lsu), .data(lsu_slot)
  );

  assign alu_slot_addr = alu_slot[AW+WIDTH-1:WIDTH];
  assign lsu_slot_addr = lsu_slot[AW+WIDTH-1:WIDTH];

  // ALU wins when alone, or when it has been starved long enough.
  assign grant_alu = v_alu && (!v_lsu || starve_cnt == SW'(STARVE_MAX));
  assign grant_lsu = v_lsu && !grant_alu;
  assign any_grant = grant_alu || grant_lsu;
  assign win_src   = grant_alu ? WB_SRC_ALU : WB_SRC_LSU;
  assign win       = (win_src == WB_SRC_ALU) ? alu_slot : lsu_slot;
  assign win_addr  = win[AW+WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!v_alu || grant_alu) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // x0 writes still drain their slot but never raise we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we    <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
    end else if (any_grant) begin
      wb_we    <= (win_addr != '0);
      wb_waddr <= win_addr;
      wb_wdata <= win[WIDTH-1:0];
    end else begin
      wb_we    <= 1'b0;
    end
  end

  logic slot_hit, wb_hit;
  assign slot_hit = (v_alu && alu_slot_addr == query_addr) ||
                    (v_lsu && lsu_slot_addr == query_addr);

`ifdef WB_BYPASS_EN
  // The in-flight write is forwarded, so it no longer needs a stall.
  assign wb_hit  = 1'b0;
  assign byp_rs1 = (wb_we && wb_waddr == byp_raddr1 && byp_raddr1 != '0) ? wb_wdata : byp_rs1_in;
  assign byp_rs2 = (wb_we && wb_waddr == byp_raddr2 && byp_raddr2 != '0) ? wb_wdata : byp_rs2_in;
`else
  logic unused_byp;
  assign unused_byp = ^{byp_raddr1, byp_raddr2};
  assign wb_hit     = wb_we && wb_waddr == query_addr;
  assign byp_rs1    = byp_rs1_in;
  assign byp_rs2    = byp_rs2_in;
`endif

  assign query_hit = (query_addr != '0) && (slot_hit || wb_hit);
  assign idle      = !v_alu && !v_lsu && !wb_we;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import risc_mini_pkg::*;

  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 0, lsu_valid = 0;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_addr = 0, lsu_addr = 0, query_addr = 0, byp_raddr1 = 0, byp_raddr2 = 0;
  logic [31:0] alu_data = 0, lsu_data = 0, byp_rs1_in = 0, byp_rs2_in = 0;
  logic        wb_we, query_hit, idle;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata, byp_rs1, byp_rs2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(32), .WIDTH(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .query_addr(query_addr), .query_hit(query_hit), .idle(idle),
    .byp_raddr1(byp_raddr1), .byp_raddr2(byp_raddr2),
    .byp_rs1_in(byp_rs1_in), .byp_rs2_in(byp_rs2_in),
    .byp_rs1(byp_rs1), .byp_rs2(byp_rs2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Register file environment: written by the DUT's write port.
  logic [31:0] rf [32];
  always @(posedge clk) if (wb_we) rf[wb_waddr] <= wb_wdata;

  // ---------------- behavioural model ----------------
  // Each source holds at most one pending request; the arbiter policy is
  // evaluated from queue occupancy and a count of consecutive ALU losses.
  wb_req_t     aq[$], lq[$];
  int          losses = 0;
  logic        m_we = 0;
  logic [4:0]  m_waddr = 0;
  logic [31:0] m_wdata = 0;

  // 0: nobody, 1: ALU, 2: LSU
  function automatic int pick();
    if (aq.size() != 0 && (lq.size() == 0 || losses == STARVE_MAX)) return 1;
    if (lq.size() != 0) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    bit ar, lr;
    wb_req_t w;
    if (!rst_n) begin
      aq.delete(); lq.delete();
      losses = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
    end else begin
      g  = pick();
      ar = (aq.size() == 0) || g == 1;
      lr = (lq.size() == 0) || g == 2;
      w  = (g == 1) ? aq[0] : (g == 2) ? lq[0] : '0;
      if (g != 0) begin
        m_we = (w.addr != 0); m_waddr = w.addr; m_wdata = w.data;
      end else m_we = 0;
      if (aq.size() == 0 || g == 1) losses = 0;
      else if (losses < STARVE_MAX) losses++;
      if (g == 1) void'(aq.pop_front());
      if (g == 2) void'(lq.pop_front());
      if (alu_valid && ar) aq.push_back('{alu_addr, alu_data});
      if (lsu_valid && lr) lq.push_back('{lsu_addr, lsu_data});
    end
  end

  function automatic bit held(input wb_req_t q[$], input logic [4:0] a);
    foreach (q[i]) if (q[i].addr == a) return 1;
    return 0;
  endfunction

  // Compare process: every negedge, all outputs against the model.
  always @(negedge clk) begin
    int g;
    bit qh;
    logic [31:0] e1, e2;
    g  = pick();
    qh = held(aq, query_addr) || held(lq, query_addr);
`ifdef WB_BYPASS_EN
    e1 = (m_we && m_waddr == byp_raddr1 && byp_raddr1 != 0) ? m_wdata : byp_rs1_in;
    e2 = (m_we && m_waddr == byp_raddr2 && byp_raddr2 != 0) ? m_wdata : byp_rs2_in;
`else
    qh = qh || (m_we && m_waddr == query_addr);
    e1 = byp_rs1_in;
    e2 = byp_rs2_in;
`endif
    chk("cmp_wb_we", {31'b0, wb_we}, {31'b0, m_we});
    chk("cmp_wb_waddr", {27'b0, wb_waddr}, {27'b0, m_waddr});
    chk("cmp_wb_wdata", wb_wdata, m_wdata);
    chk("cmp_alu_ready", {31'b0, alu_ready}, {31'b0, aq.size() == 0 || g == 1});
    chk("cmp_lsu_ready", {31'b0, lsu_ready}, {31'b0, lq.size() == 0 || g == 2});
    chk("cmp_idle", {31'b0, idle}, {31'b0, aq.size() == 0 && lq.size() == 0 && !m_we});
    chk("cmp_query_hit", {31'b0, query_hit}, {31'b0, query_addr != 0 && qh});
    chk("cmp_byp_rs1", byp_rs1, e1);
    chk("cmp_byp_rs2", byp_rs2, e2);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_we"}, {31'b0, wb_we}, 0);
    chk({tag, "_waddr"}, {27'b0, wb_waddr}, 0);
    chk({tag, "_wdata"}, wb_wdata, 0);
    chk({tag, "_alu_ready"}, {31'b0, alu_ready}, 1);
    chk({tag, "_lsu_ready"}, {31'b0, lsu_ready}, 1);
    chk({tag, "_idle"}, {31'b0, idle}, 1);
  endtask

  string seq;

  initial begin
    step(); step();
    chk_reset_state("por");
    rst_n = 1;
    step();

    // Single ALU write to x5.
    alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF;
    step();                               // edge E
    alu_valid = 0;
    step();                               // E+1
    chk("alu_single_we", {31'b0, wb_we}, 1);
    chk("alu_single_waddr", {27'b0, wb_waddr}, 5);
    chk("alu_single_wdata", wb_wdata, 32'hDEADBEEF);
    step();                               // E+2
    chk("alu_single_rf", rf[5], 32'hDEADBEEF);

    // LSU write to x0 is consumed silently.
    lsu_valid = 1; lsu_addr = 0; lsu_data = 32'h1234; query_addr = 0;
    #1 chk("x0_lsu_ready", {31'b0, lsu_ready}, 1);
    step();
    lsu_valid = 0;
    chk("x0_query", {31'b0, query_hit}, 0);
    step();
    chk("x0_we", {31'b0, wb_we}, 0);
    chk("x0_idle", {31'b0, idle}, 1);

    // Sustained contention: expect L,L,L,A repeating.
    alu_valid = 1; alu_addr = 10; alu_data = 32'hA0;
    lsu_valid = 1; lsu_addr = 20; lsu_data = 32'hB0;
    seq = "";
    step();                               // both slots load
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin alu_valid = 0; lsu_valid = 0; end
      step();
      if (wb_we) seq = {seq, (wb_waddr == 20) ? "L" : "A"};
    end
    checks++;
    if (seq != "LLLALLLA") begin
      errors++;
      $display("FAIL contention_order actual=%s expected=LLLALLLA", seq);
    end
    repeat (4) step();

    // Hazard query on a held ALU write to x7.
    alu_valid = 1; alu_addr = 7; alu_data = 32'h77; query_addr = 7;
    step();                               // E: held in slot
    alu_valid = 0;
    chk("haz_slot", {31'b0, query_hit}, 1);
    query_addr = 8;
    #1 chk("haz_other", {31'b0, query_hit}, 0);
    query_addr = 7;
    step();                               // E+1: write in flight
`ifdef WB_BYPASS_EN
    chk("haz_inflight", {31'b0, query_hit}, 0);
`else
    chk("haz_inflight", {31'b0, query_hit}, 1);
`endif
    step();                               // E+2: regfile written
    chk("haz_done", {31'b0, query_hit}, 0);
    chk("haz_rf", rf[7], 32'h77);

    // Bypass of the in-flight write to x3.
    alu_valid = 1; alu_addr = 3; alu_data = 32'hA5;
    step();
    alu_valid = 0;
    step();
    byp_raddr1 = 3; byp_rs1_in = 0; byp_raddr2 = 4; byp_rs2_in = 32'h55;
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_rs1", byp_rs1, 32'hA5);
`else
    chk("byp_rs1", byp_rs1, 32'h0);
`endif
    chk("byp_rs2", byp_rs2, 32'h55);
    step();
    byp_raddr1 = 0; byp_raddr2 = 0; byp_rs2_in = 0;

    // Mixed traffic pattern, checked by the model.
    for (int i = 0; i < 20; i++) begin
      alu_valid = (i % 3) != 0; alu_addr = 5'(i);     alu_data = 32'h100 + i;
      lsu_valid = (i % 2) == 0; lsu_addr = 5'(i + 1); lsu_data = 32'h200 + i;
      query_addr = 5'(i + 1);
      step();
    end

    // Async reset in the middle of contention.
    alu_valid = 1; lsu_valid = 1; alu_addr = 9; lsu_addr = 11;
    step(); step();
    rst_n = 0;
    #1 chk_reset_state("midrst");
    alu_valid = 0; lsu_valid = 0;
    step();
    rst_n = 1;
    step(); step();
    chk("post_rst_idle", {31'b0, idle}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
